ans_encoder: RTL and testbench

- Streaming rANS encoder: accepts one symbol per handshake, renormalises by shifting out 4-bit nibbles, and updates a STATE_WIDTH-bit coder state.
- Uses the same counts/cumulative frequency tables as the on-chip decoder.
- On flush, emits the final state, most significant nibble first.
- The host reverses the whole emitted nibble stream before feeding it to the decoder. Symbols are encoded in reverse of the desired decode order.

---
 rtl/ans_pkg.sv | 20 ++
 rtl/ans_encoder_if.sv | 14 +
 rtl/ans_enc_step.sv | 53 +++++
 rtl/ans_encoder.sv | 162 ++++++++++++++++
 tb/tb_ans_encoder.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ans_pkg.sv
// Shared rANS constants: symbol/nibble width, count width, alphabet size, coder state width.
`ifndef ANS_DEFINES
`define ANS_DEFINES
`define SYM_WIDTH 4
`define CNT_WIDTH 4
`define SYM_COUNT 16
`define STATE_WIDTH 16
`endif

package ans_pkg;
   localparam int SYM_WIDTH   = `SYM_WIDTH;
   localparam int CNT_WIDTH   = `CNT_WIDTH;
   localparam int SYM_COUNT   = `SYM_COUNT;
   localparam int STATE_WIDTH = `STATE_WIDTH;
   localparam int NIB_WIDTH   = 4;
   localparam int CUM_WIDTH   = CNT_WIDTH + SYM_WIDTH;
   localparam int EXT_WIDTH   = STATE_WIDTH + NIB_WIDTH;
   localparam int NIB_COUNT   = STATE_WIDTH / NIB_WIDTH;
   localparam int PTR_WIDTH   = (NIB_COUNT > 1) ? $clog2(NIB_COUNT) : 1;
endpackage

// File: rtl/ans_encoder_if.sv
// Symbol-in / nibble-out four-phase handshake bundle between host (master) and encoder (slave).
interface ans_encoder_if;
   import ans_pkg::*;

   logic [SYM_WIDTH-1:0] in;
   logic                 in_vld;
   logic                 in_rdy;
   logic [SYM_WIDTH-1:0] out;
   logic                 out_vld;
   logic                 out_rdy;

   modport master (output in, in_vld, out_rdy, input in_rdy, out, out_vld);
   modport slave  (input in, in_vld, out_rdy, output in_rdy, out, out_vld);
endinterface

// File: rtl/ans_enc_step.sv
// rANS state update x' = (x / f) * M + (x % f) + c as a registered divide, multiply, add sequence.
// done rises two enabled cycles after start; renorm is a combinational x >= f*16 test.
module ans_enc_step
   import ans_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ena,
   input  logic                   start,
   input  logic [STATE_WIDTH-1:0] x,
   input  logic [CNT_WIDTH-1:0]   f,
   input  logic [CUM_WIDTH-1:0]   c,
   input  logic [CUM_WIDTH-1:0]   m,
   output logic                   renorm,
   output logic                   done,
   output logic [STATE_WIDTH-1:0] x_next
);
   logic [EXT_WIDTH-1:0] x_ext;
   logic [EXT_WIDTH-1:0] f_ext;
   logic [EXT_WIDTH-1:0] q;
   logic [EXT_WIDTH-1:0] r;
   logic [EXT_WIDTH-1:0] t;
   logic                 phase1;
   logic                 phase2;

   assign x_ext  = EXT_WIDTH'(x);
   assign f_ext  = EXT_WIDTH'(f);
   assign renorm = x_ext >= (f_ext << NIB_WIDTH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q      <= '0;
         r      <= '0;
         t      <= '0;
         phase1 <= 1'b0;
         phase2 <= 1'b0;
      end else if (ena) begin
         phase1 <= start;
         phase2 <= phase1;
         if (start) begin
            // zero-frequency symbols never reach here; the guard only keeps X out of the divider
            q <= (f == '0) ? '0 : x_ext / f_ext;
            r <= (f == '0) ? '0 : x_ext % f_ext;
         end
         if (phase1) begin
            t <= q * EXT_WIDTH'(m);
         end
      end
   end

   assign done   = phase2;
   assign x_next = STATE_WIDTH'(t + r + EXT_WIDTH'(c));
endmodule

// File: rtl/ans_encoder.sv
// Streaming rANS encoder: one symbol per four-phase handshake, renormalising nibbles out LSB first,
// final state flushed MS nibble first. ena low freezes every register, including mid-handshake.
module ans_encoder
   import ans_pkg::*;
(
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           ena,
   input  logic [CNT_WIDTH*SYM_COUNT-1:0] counts_unpacked,
   input  logic [CUM_WIDTH*SYM_COUNT-1:0] cumulative_unpacked,
   input  logic                           flush,
   output logic                           err,
   ans_encoder_if.slave                   bus
);
   typedef enum logic [2:0] {WAIT, RENORM, ENC0, ENC1, ENC2, FLUSH} state_t;

   state_t                 state, state_nxt;
   logic [SYM_WIDTH-1:0]   sym, sym_nxt;
   logic [STATE_WIDTH-1:0] x, x_nxt;
   logic [PTR_WIDTH-1:0]   ptr, ptr_nxt;
   logic                   rdy, rdy_nxt;
   logic                   vld, vld_nxt;
   logic [SYM_WIDTH-1:0]   nib, nib_nxt;
   logic                   err_nxt;

   logic [CUM_WIDTH-1:0]   m;
   logic [CNT_WIDTH-1:0]   f_in;
   logic [CNT_WIDTH-1:0]   f_sym;
   logic [SYM_WIDTH-1:0]   sym_prev;
   logic [CUM_WIDTH-1:0]   c_sym;
   logic                   start;
   logic                   renorm;
   logic                   done;
   logic [STATE_WIDTH-1:0] x_step;

   assign m        = cumulative_unpacked[(SYM_COUNT-1)*CUM_WIDTH +: CUM_WIDTH];
   assign f_in     = counts_unpacked[bus.in*CNT_WIDTH +: CNT_WIDTH];
   assign f_sym    = counts_unpacked[sym*CNT_WIDTH +: CNT_WIDTH];
   // the tables hold inclusive prefix sums, so a symbol's start offset is its predecessor's entry
   assign sym_prev = sym - 1'b1;
   assign c_sym    = (sym == '0) ? '0 : cumulative_unpacked[sym_prev*CUM_WIDTH +: CUM_WIDTH];

   ans_enc_step u_step (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .start  (start),
      .x      (x),
      .f      (f_sym),
      .c      (c_sym),
      .m      (m),
      .renorm (renorm),
      .done   (done),
      .x_next (x_step)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= WAIT;
         sym   <= '0;
         x     <= STATE_WIDTH'(m);
         ptr   <= '0;
         rdy   <= 1'b1;
         vld   <= 1'b0;
         nib   <= '0;
         err   <= 1'b0;
      end else if (ena) begin
         state <= state_nxt;
         sym   <= sym_nxt;
         x     <= x_nxt;
         ptr   <= ptr_nxt;
         rdy   <= rdy_nxt;
         vld   <= vld_nxt;
         nib   <= nib_nxt;
         err   <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      sym_nxt   = sym;
      x_nxt     = x;
      ptr_nxt   = ptr;
      rdy_nxt   = rdy;
      vld_nxt   = vld;
      nib_nxt   = nib;
      err_nxt   = err;
      start     = 1'b0;
      case (state)
         WAIT: begin
            if (!rdy && !bus.in_vld) begin
               rdy_nxt = 1'b1;
            end
            if (bus.in_vld && rdy) begin
               rdy_nxt = 1'b0;
               sym_nxt = bus.in;
               if (f_in == '0) begin
                  err_nxt = 1'b1;
               end else begin
                  state_nxt = RENORM;
               end
            end else if (flush && !bus.in_vld) begin
               rdy_nxt   = 1'b0;
               ptr_nxt   = PTR_WIDTH'(NIB_COUNT - 1);
               state_nxt = FLUSH;
            end
         end
         RENORM: begin
            // a nibble leaves x only once acknowledged, so the range check always sees the live state
            if (vld) begin
               if (bus.out_rdy) begin
                  vld_nxt = 1'b0;
                  x_nxt   = x >> NIB_WIDTH;
               end
            end else if (renorm) begin
               if (!bus.out_rdy) begin
                  vld_nxt = 1'b1;
                  nib_nxt = x[NIB_WIDTH-1:0];
               end
            end else begin
               state_nxt = ENC0;
            end
         end
         ENC0: begin
            start     = 1'b1;
            state_nxt = ENC1;
         end
         ENC1: begin
            state_nxt = ENC2;
         end
         ENC2: begin
            if (done) begin
               x_nxt     = x_step;
               state_nxt = WAIT;
            end
         end
         FLUSH: begin
            if (vld) begin
               if (bus.out_rdy) begin
                  vld_nxt = 1'b0;
                  if (ptr == '0) begin
                     x_nxt     = STATE_WIDTH'(m);
                     state_nxt = WAIT;
                  end else begin
                     ptr_nxt = ptr - 1'b1;
                  end
               end
            end else if (!bus.out_rdy) begin
               vld_nxt = 1'b1;
               nib_nxt = x[ptr*NIB_WIDTH +: NIB_WIDTH];
            end
         end
         default: begin
            state_nxt = WAIT;
         end
      endcase
   end

   assign bus.in_rdy  = rdy;
   assign bus.out_vld = vld;
   assign bus.out     = nib;
endmodule

// File: tb/tb_ans_encoder.sv
// Bench for ans_encoder: directed table cases plus a random round trip through a reference decoder.
module tb_ans_encoder;
   import ans_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ena = 1'b1;
   logic flush = 1'b0;
   logic err;
   logic [CNT_WIDTH*SYM_COUNT-1:0] counts_unpacked = '0;
   logic [CUM_WIDTH*SYM_COUNT-1:0] cumulative_unpacked = '0;

   ans_encoder_if bus();

   ans_encoder dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .ena                 (ena),
      .counts_unpacked     (counts_unpacked),
      .cumulative_unpacked (cumulative_unpacked),
      .flush               (flush),
      .err                 (err),
      .bus                 (bus)
   );

   always #5 clk = ~clk;

   int compared = 0;
   int mismatched = 0;
   int ftab[SYM_COUNT];
   int ctab[SYM_COUNT];
   int m_tab;
   int got[$];          // every nibble ever acknowledged; only the consumer writes it
   int stream_base;     // index in got where the current test's stream starts
   int flush_base;
   int ack_mode = 0;    // 0 = four-phase consumer, 1 = out_rdy held high, 2 = out_rdy held low
   int stall_pct = 0;
   int mx;              // reference coder state
   int exp_q[$];        // reference nibble stream since last reset

   initial begin
      bus.out_rdy = 1'b0;
      forever begin
         @(negedge clk);
         if (ack_mode == 1) bus.out_rdy = 1'b1;
         else if (ack_mode == 2) bus.out_rdy = 1'b0;
         else if (bus.out_rdy) begin
            if (!bus.out_vld) bus.out_rdy = 1'b0;
         end else if (bus.out_vld && $urandom_range(99, 0) >= stall_pct) begin
            got.push_back(int'(bus.out));
            bus.out_rdy = 1'b1;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

   // reference encoder straight from the rANS definition
   function automatic void model_sym(int s);
      int c;
      if (ftab[s] == 0) return;
      c = 0;
      if (s > 0) c = ctab[s-1];
      while (mx >= ftab[s] * 16) begin
         exp_q.push_back(mx % 16);
         mx = mx / 16;
      end
      mx = ((mx / ftab[s]) * m_tab + (mx % ftab[s]) + c) % (1 << STATE_WIDTH);
   endfunction

   function automatic void model_flush();
      for (int k = NIB_COUNT - 1; k >= 0; k--) exp_q.push_back((mx >> (4 * k)) % 16);
      mx = m_tab;
   endfunction

   task automatic apply_reset();
      int acc = 0;
      @(negedge clk);
      rst_n = 1'b0;
      bus.in_vld = 1'b0;
      bus.in = '0;
      flush = 1'b0;
      ena = 1'b1;
      ack_mode = 0;
      stall_pct = 0;
      for (int s = 0; s < SYM_COUNT; s++) begin
         acc += ftab[s];
         ctab[s] = acc;
         counts_unpacked[s*CNT_WIDTH +: CNT_WIDTH] = CNT_WIDTH'(ftab[s]);
         cumulative_unpacked[s*CUM_WIDTH +: CUM_WIDTH] = CUM_WIDTH'(acc);
      end
      m_tab = acc;
      mx = m_tab;
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      stream_base = got.size();
   endtask

   task automatic set_small_tables();
      for (int s = 0; s < SYM_COUNT; s++) ftab[s] = 0;
      ftab[0] = 3;
      ftab[1] = 1;
   endtask

   task automatic wait_rdy(input string what);
      int n = 0;
      while (!bus.in_rdy && n < 600) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_rdy) begin
         compared++;
         mismatched++;
         $display("FAIL %s_timeout: in_rdy=%0b after %0d cycles, want 1", what, bus.in_rdy, n);
      end
   endtask

   task automatic send_sym(input int s);
      wait_rdy("send");
      bus.in = SYM_WIDTH'(s);
      bus.in_vld = 1'b1;
      model_sym(s);
      @(negedge clk);
      bus.in_vld = 1'b0;
   endtask

   task automatic start_flush();
      wait_rdy("flush_start");
      flush_base = got.size();
      flush = 1'b1;
   endtask

   task automatic finish_flush();
      int n = 0;
      while (got.size() == flush_base && n < 600) begin
         @(negedge clk);
         n++;
      end
      flush = 1'b0;
      while (got.size() < flush_base + NIB_COUNT && n < 1200) begin
         @(negedge clk);
         n++;
      end
      wait_rdy("flush_end");
      if (got.size() < flush_base + NIB_COUNT) begin
         compared++;
         mismatched++;
         $display("FAIL flush_count: got %0d nibbles, want %0d", got.size() - flush_base, NIB_COUNT);
      end
      model_flush();
   endtask

   task automatic test_reset();
      set_small_tables();
      apply_reset();
      compared++;
      if (bus.in_rdy !== 1'b1) begin mismatched++; $display("FAIL reset_in_rdy: got %0b want 1", bus.in_rdy); end
      compared++;
      if (bus.out_vld !== 1'b0) begin mismatched++; $display("FAIL reset_out_vld: got %0b want 0", bus.out_vld); end
      compared++;
      if (bus.out !== '0) begin mismatched++; $display("FAIL reset_out: got %0h want 0", bus.out); end
      compared++;
      if (err !== 1'b0) begin mismatched++; $display("FAIL reset_err: got %0b want 0", err); end
   endtask

   task automatic test_basic();
      int want[$];
      want = '{0, 0, 1, 7};
      set_small_tables();
      apply_reset();
      send_sym(0);
      send_sym(1);
      start_flush();
      finish_flush();
      compared++;
      if (got.size() - stream_base != want.size()) begin
         mismatched++;
         $display("FAIL basic_len: got %0d nibbles want %0d", got.size() - stream_base, want.size());
      end else begin
         for (int i = 0; i < want.size(); i++) begin
            compared++;
            if (got[stream_base+i] !== want[i]) begin
               mismatched++;
               $display("FAIL basic_nib%0d: got %0d want %0d", i, got[stream_base+i], want[i]);
            end
         end
      end
      compared++;
      if (err !== 1'b0) begin mismatched++; $display("FAIL basic_err: got %0b want 0", err); end
   endtask

   task automatic test_renorm();
      int want[$];
      want = '{7, 0, 0, 0, 7};
      set_small_tables();
      apply_reset();
      send_sym(0);
      send_sym(1);
      send_sym(1);
      start_flush();
      finish_flush();
      compared++;
      if (got.size() - stream_base != want.size()) begin
         mismatched++;
         $display("FAIL renorm_len: got %0d nibbles want %0d", got.size() - stream_base, want.size());
      end else begin
         for (int i = 0; i < want.size(); i++) begin
            compared++;
            if (got[stream_base+i] !== want[i]) begin
               mismatched++;
               $display("FAIL renorm_nib%0d: got %0d want %0d", i, got[stream_base+i], want[i]);
            end
         end
      end
   endtask

   task automatic test_zero_freq();
      int want[$];
      want = '{0, 0, 0, 5};
      set_small_tables();
      apply_reset();
      send_sym(5);
      wait_rdy("zero_freq");
      compared++;
      if (err !== 1'b1) begin mismatched++; $display("FAIL zero_err_set: got %0b want 1", err); end
      compared++;
      if (got.size() != stream_base) begin
         mismatched++;
         $display("FAIL zero_no_out: got %0d nibbles want 0", got.size() - stream_base);
      end
      send_sym(0);
      wait_rdy("zero_next");
      compared++;
      if (err !== 1'b1) begin mismatched++; $display("FAIL zero_err_sticky: got %0b want 1", err); end
      start_flush();
      finish_flush();
      compared++;
      if (got.size() - stream_base != want.size()) begin
         mismatched++;
         $display("FAIL zero_len: got %0d nibbles want %0d", got.size() - stream_base, want.size());
      end else begin
         for (int i = 0; i < want.size(); i++) begin
            compared++;
            if (got[stream_base+i] !== want[i]) begin
               mismatched++;
               $display("FAIL zero_nib%0d: got %0d want %0d", i, got[stream_base+i], want[i]);
            end
         end
      end
   endtask

   task automatic test_flush_hold();
      int want[$];
      int early = 0;
      int n = 0;
      want = '{0, 0, 1, 7};
      set_small_tables();
      apply_reset();
      send_sym(0);
      send_sym(1);
      wait_rdy("hold");
      ack_mode = 1;
      @(negedge clk);
      start_flush();
      repeat (12) begin
         @(negedge clk);
         if (bus.out_vld !== 1'b0) early++;
      end
      compared++;
      if (early != 0) begin mismatched++; $display("FAIL hold_out_vld: out_vld high on %0d cycles want 0", early); end
      ack_mode = 0;
      while (got.size() == flush_base && n < 200) begin
         @(negedge clk);
         n++;
      end
      ena = 1'b0;
      repeat (10) @(negedge clk);
      ena = 1'b1;
      finish_flush();
      compared++;
      if (got.size() - stream_base != want.size()) begin
         mismatched++;
         $display("FAIL hold_len: got %0d nibbles want %0d", got.size() - stream_base, want.size());
      end else begin
         for (int i = 0; i < want.size(); i++) begin
            compared++;
            if (got[stream_base+i] !== want[i]) begin
               mismatched++;
               $display("FAIL hold_nib%0d: got %0d want %0d", i, got[stream_base+i], want[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int want[$];
      int n = 0;
      want = '{0, 0, 0, 5};
      set_small_tables();
      apply_reset();
      send_sym(5);
      send_sym(0);
      send_sym(1);
      wait_rdy("mid_pre");
      ack_mode = 2;
      send_sym(1);
      while (bus.out_vld !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      compared++;
      if (bus.out_vld !== 1'b1 || bus.out !== 4'd7) begin
         mismatched++;
         $display("FAIL mid_renorm_nib: out_vld=%0b out=%0d want 1 and 7", bus.out_vld, bus.out);
      end
      rst_n = 1'b0;
      @(negedge clk);
      compared++;
      if (bus.out_vld !== 1'b0) begin mismatched++; $display("FAIL mid_out_vld: got %0b want 0", bus.out_vld); end
      compared++;
      if (bus.in_rdy !== 1'b1) begin mismatched++; $display("FAIL mid_in_rdy: got %0b want 1", bus.in_rdy); end
      compared++;
      if (err !== 1'b0) begin mismatched++; $display("FAIL mid_err: got %0b want 0", err); end
      apply_reset();
      send_sym(0);
      start_flush();
      finish_flush();
      compared++;
      if (got.size() - stream_base != want.size()) begin
         mismatched++;
         $display("FAIL mid_len: got %0d nibbles want %0d", got.size() - stream_base, want.size());
      end else begin
         for (int i = 0; i < want.size(); i++) begin
            compared++;
            if (got[stream_base+i] !== want[i]) begin
               mismatched++;
               $display("FAIL mid_nib%0d: got %0d want %0d", i, got[stream_base+i], want[i]);
            end
         end
      end
   endtask

   task automatic test_round_trip();
      int orig[200];
      int rev[$];
      int pos = 0;
      int dx = 0;
      int bad = 0;
      for (int s = 0; s < SYM_COUNT; s++) ftab[s] = 0;
      ftab[0] = 5;
      ftab[1] = 3;
      ftab[2] = 7;
      ftab[3] = 1;
      apply_reset();
      stall_pct = 40;
      for (int i = 0; i < 200; i++) orig[i] = int'($urandom_range(3, 0));
      for (int i = 199; i >= 0; i--) send_sym(orig[i]);
      start_flush();
      finish_flush();
      compared++;
      if (got.size() - stream_base != exp_q.size()) begin
         mismatched++;
         $display("FAIL rt_len: got %0d nibbles want %0d", got.size() - stream_base, exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            compared++;
            if (got[stream_base+i] !== exp_q[i]) begin
               mismatched++;
               $display("FAIL rt_nib%0d: got %0d want %0d", i, got[stream_base+i], exp_q[i]);
            end
         end
      end
      for (int i = got.size() - 1; i >= stream_base; i--) rev.push_back(got[i]);
      for (int k = 0; k < NIB_COUNT && pos < rev.size(); k++) begin
         dx = dx | (rev[pos] << (4 * k));
         pos++;
      end
      for (int i = 0; i < 200; i++) begin
         int slot = dx % m_tab;
         int s = 0;
         int c = 0;
         while (s < SYM_COUNT - 1 && slot >= ctab[s]) s++;
         if (s > 0) c = ctab[s-1];
         dx = ftab[s] * (dx / m_tab) + slot - c;
         while (dx < m_tab && pos < rev.size()) begin
            dx = dx * 16 + rev[pos];
            pos++;
         end
         compared++;
         if (s !== orig[i]) begin
            mismatched++;
            bad++;
            if (bad < 5) $display("FAIL rt_dec%0d: decoded %0d want %0d", i, s, orig[i]);
         end
      end
      compared++;
      if (dx != m_tab || pos != rev.size()) begin
         mismatched++;
         $display("FAIL rt_final: state %0d used %0d of %0d, want %0d and all", dx, pos, rev.size(), m_tab);
      end
      compared++;
      if (err !== 1'b0) begin mismatched++; $display("FAIL rt_err: got %0b want 0", err); end
   endtask

   initial begin
      bus.in = '0;
      bus.in_vld = 1'b0;
      test_reset();
      test_basic();
      test_renorm();
      test_zero_freq();
      test_flush_hold();
      test_reset_mid();
      test_round_trip();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
